// File: rtl/hs_multi_seeker_aligner_if.sv
// Gearbox-to-aligner bundle: buffer window in, sync status and chosen offset out.
// The master side drives the gearbox data; the slave side is the aligner.
interface hs_multi_seeker_aligner_if #(
    parameter int BUF_W = 194,
    parameter int CNT_W = 6,
    parameter int POS_W = 7,
    parameter int WIN_W = 1
);
    logic [BUF_W-1:0] gbox_buffer;
    logic [CNT_W-1:0] gbox_cnt;
    logic             buffer_dv;
    logic             is_synced;
    logic [POS_W-1:0] offset_pos;
    logic [WIN_W-1:0] winner_idx;
    logic             lock_lost;

    modport master (
        output gbox_buffer, gbox_cnt, buffer_dv,
        input  is_synced, offset_pos, winner_idx, lock_lost
    );

    modport slave (
        input  gbox_buffer, gbox_cnt, buffer_dv,
        output is_synced, offset_pos, winner_idx, lock_lost
    );
endinterface

// File: rtl/hs_multi_seeker_aligner.sv
// 64b/66b sync-header aligner: parallel seekers hunt interleaved offsets, sticky arbiter picks one.
// Seekers step on buffer_dv edges; outputs follow one clock later. No backpressure: buffer_dv qualifies input.
module hs_multi_seeker_aligner #(
    parameter int BUF_W      = 194,
    parameter int CNT_W      = 6,
    parameter int POS_W      = 7,
    parameter int N_SEEKERS  = 2,
    parameter int MAX_POS    = 65,
    parameter int LOCK_CNT   = 16,
    parameter int ERR_THRESH = 4,
    parameter int WIN_W      = (N_SEEKERS > 1) ? $clog2(N_SEEKERS) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    hs_multi_seeker_aligner_if.slave      bus
);
    localparam int VC_W  = $clog2(LOCK_CNT + 1);
    localparam int EC_W  = $clog2(ERR_THRESH + 1);
    localparam int SEL_N = 1 << WIN_W;

    typedef enum logic [1:0] {S_HUNT, S_VERIFY, S_LOCKED} seek_state_t;

    seek_state_t      st_q   [N_SEEKERS];
    seek_state_t      st_d   [N_SEEKERS];
    logic [POS_W-1:0] pos_q  [N_SEEKERS];
    logic [POS_W-1:0] pos_d  [N_SEEKERS];
    logic [VC_W-1:0]  vcnt_q [N_SEEKERS];
    logic [VC_W-1:0]  vcnt_d [N_SEEKERS];
    logic [EC_W-1:0]  ecnt_q [N_SEEKERS];
    logic [EC_W-1:0]  ecnt_d [N_SEEKERS];
    logic             hdr_ok [N_SEEKERS];
    logic [POS_W-1:0] adv_pos[N_SEEKERS];

    logic             is_synced_q, lock_lost_q, any_lock;
    logic [POS_W-1:0] offset_q, off_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [SEL_N-1:0] locked_vec;

    // Header check and the next candidate offset (wraps back to the seeker's own index).
    always_comb begin : hdr_chk
        logic [POS_W:0] hb;
        logic [POS_W:0] psum;
        hb   = '0;
        psum = '0;
        for (int k = 0; k < N_SEEKERS; k++) begin
            hb         = (POS_W+1)'(bus.gbox_cnt) + {1'b0, pos_q[k]};
            hdr_ok[k]  = bus.gbox_buffer[hb + 1'b1] ^ bus.gbox_buffer[hb];
            psum       = {1'b0, pos_q[k]} + (POS_W+1)'(N_SEEKERS);
            adv_pos[k] = (psum > (POS_W+1)'(MAX_POS)) ? POS_W'(k) : psum[POS_W-1:0];
        end
    end

    always_comb begin : seek_next
        for (int k = 0; k < N_SEEKERS; k++) begin
            st_d[k]   = st_q[k];
            pos_d[k]  = pos_q[k];
            vcnt_d[k] = vcnt_q[k];
            ecnt_d[k] = ecnt_q[k];
            if (bus.buffer_dv && (k <= MAX_POS)) begin
                case (st_q[k])
                    S_HUNT: begin
                        if (hdr_ok[k]) begin
                            vcnt_d[k] = VC_W'(1);
                            ecnt_d[k] = '0;
                            st_d[k]   = (LOCK_CNT == 1) ? S_LOCKED : S_VERIFY;
                        end else begin
                            pos_d[k] = adv_pos[k];
                        end
                    end
                    S_VERIFY: begin
                        if (!hdr_ok[k]) begin
                            st_d[k]   = S_HUNT;
                            vcnt_d[k] = '0;
                            pos_d[k]  = adv_pos[k];
                        end else if (vcnt_q[k] >= VC_W'(LOCK_CNT - 1)) begin
                            st_d[k]   = S_LOCKED;
                            vcnt_d[k] = VC_W'(LOCK_CNT);
                            ecnt_d[k] = '0;
                        end else begin
                            vcnt_d[k] = vcnt_q[k] + 1'b1;
                        end
                    end
                    S_LOCKED: begin
                        if (hdr_ok[k]) begin
                            ecnt_d[k] = '0;
                        end else if (ecnt_q[k] >= EC_W'(ERR_THRESH - 1)) begin
                            st_d[k]   = S_HUNT;
                            ecnt_d[k] = '0;
                            vcnt_d[k] = '0;
                            pos_d[k]  = adv_pos[k];
                        end else begin
                            ecnt_d[k] = ecnt_q[k] + 1'b1;
                        end
                    end
                    default: st_d[k] = S_HUNT;
                endcase
            end
        end
    end

    // Sticky arbitration: a still-locked winner keeps the grant, else lowest locked index.
    always_comb begin : arb
        locked_vec = '0;
        for (int k = 0; k < N_SEEKERS; k++) begin
            locked_vec[k] = (st_q[k] == S_LOCKED);
        end
        any_lock = |locked_vec;
        win_d    = win_q;
        if (!(is_synced_q && locked_vec[win_q])) begin
            for (int k = N_SEEKERS - 1; k >= 0; k--) begin
                if (locked_vec[k]) win_d = WIN_W'(k);
            end
        end
        off_d = offset_q;
        for (int k = 0; k < N_SEEKERS; k++) begin
            if (WIN_W'(k) == win_d) off_d = pos_q[k];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < N_SEEKERS; k++) begin
                st_q[k]   <= S_HUNT;
                pos_q[k]  <= POS_W'(k);
                vcnt_q[k] <= '0;
                ecnt_q[k] <= '0;
            end
            is_synced_q <= 1'b0;
            lock_lost_q <= 1'b0;
            offset_q    <= '0;
            win_q       <= '0;
        end else begin
            for (int k = 0; k < N_SEEKERS; k++) begin
                st_q[k]   <= st_d[k];
                pos_q[k]  <= pos_d[k];
                vcnt_q[k] <= vcnt_d[k];
                ecnt_q[k] <= ecnt_d[k];
            end
            is_synced_q <= any_lock;
            lock_lost_q <= is_synced_q & ~any_lock;
            if (any_lock) begin
                win_q    <= win_d;
                offset_q <= off_d;
            end
        end
    end

    assign bus.is_synced  = is_synced_q;
    assign bus.offset_pos = offset_q;
    assign bus.winner_idx = win_q;
    assign bus.lock_lost  = lock_lost_q;
endmodule
